// File: rtl/pc_sequencer.sv
// Program counter owner and instruction-cycle sequencer: BOOT -> FETCH -> EXEC,
// with a fetch handshake timeout, retire counting and a terminal HALTED state.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int          FETCH_TIMEOUT = 16,
  parameter int          CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             imem_ack,
  input  logic             ex_done,
  input  logic             stall,
  input  logic             halt,
  input  logic             branch_taken,
  input  logic [31:0]      branch_off,
  input  logic             jump_en,
  input  logic [25:0]      jump_target,
  output logic [31:0]      PC_out,
  output logic             imem_req,
  output logic             instr_valid,
  output logic             halted,
  output logic             fetch_err,
  output logic [CNT_W-1:0] retire_count
);

  localparam int TO_W = $clog2(FETCH_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(FETCH_TIMEOUT - 1);

  typedef enum logic [1:0] {BOOT, FETCH, EXEC, HALTED} state_t;

  state_t           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic             imem_req_q, imem_req_d;
  logic             instr_valid_q, instr_valid_d;
  logic             halted_q, halted_d;
  logic             fetch_err_q, fetch_err_d;
  logic [CNT_W-1:0] retire_count_q, retire_count_d;
  logic [TO_W-1:0]  tmo_q, tmo_d;

  logic [31:0] seq_pc;
  logic [31:0] next_pc;

  // Jump keeps the 256 MB region of the sequential PC; all adds wrap mod 2^32.
  always_comb begin
    seq_pc = pc_q + 32'd4;
    if (jump_en)
      next_pc = {seq_pc[31:28], jump_target, 2'b00};
    else if (branch_taken)
      next_pc = seq_pc + {branch_off[29:0], 2'b00};
    else
      next_pc = seq_pc;
  end

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    imem_req_d     = imem_req_q;
    instr_valid_d  = 1'b0;
    halted_d       = halted_q;
    fetch_err_d    = fetch_err_q;
    retire_count_d = retire_count_q;
    tmo_d          = tmo_q;

    unique case (state_q)
      BOOT: begin
        pc_d       = RESET_PC;
        state_d    = FETCH;
        imem_req_d = 1'b1;
      end
      FETCH: begin
        // An ack on the final allowed cycle still counts as a successful fetch.
        if (imem_ack) begin
          state_d       = EXEC;
          imem_req_d    = 1'b0;
          instr_valid_d = 1'b1;
          tmo_d         = '0;
        end else if (tmo_q == TO_LAST) begin
          state_d     = HALTED;
          imem_req_d  = 1'b0;
          fetch_err_d = 1'b1;
          halted_d    = 1'b1;
          tmo_d       = '0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      EXEC: begin
        if (ex_done && !stall) begin
          pc_d           = next_pc;
          retire_count_d = retire_count_q + CNT_W'(1);
          if (halt) begin
            state_d  = HALTED;
            halted_d = 1'b1;
          end else begin
            state_d    = FETCH;
            imem_req_d = 1'b1;
          end
        end
      end
      HALTED: begin
        imem_req_d = 1'b0;
        halted_d   = 1'b1;
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= BOOT;
      pc_q           <= RESET_PC;
      imem_req_q     <= 1'b0;
      instr_valid_q  <= 1'b0;
      halted_q       <= 1'b0;
      fetch_err_q    <= 1'b0;
      retire_count_q <= '0;
      tmo_q          <= '0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      imem_req_q     <= imem_req_d;
      instr_valid_q  <= instr_valid_d;
      halted_q       <= halted_d;
      fetch_err_q    <= fetch_err_d;
      retire_count_q <= retire_count_d;
      tmo_q          <= tmo_d;
    end
  end

  assign PC_out       = pc_q;
  assign imem_req     = imem_req_q;
  assign instr_valid  = instr_valid_q;
  assign halted       = halted_q;
  assign fetch_err    = fetch_err_q;
  assign retire_count = retire_count_q;

endmodule
